// File: rtl/fetch_pcreg.sv
// Fetch-stage PC register and single-outstanding instruction requester.
// Holds the fetch PC, issues one bus request at a time and presents the result to decode.
module fetch_pcreg #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] pc,
  input  logic [63:0] pcplus4,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc
);

  localparam logic [1:0] S_REQ     = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]  state;
  logic [63:0] req_addr;
  logic [31:0] instr_buf;
  logic        exc_buf;
  logic        misaligned;

  assign misaligned = req_addr[1:0] != 2'b00;

  assign ireq_valid = !reset && ((state == S_REQ && !misaligned) || state == S_DISCARD);
  assign ireq_addr  = req_addr;
  assign out_valid  = !reset && state == S_HOLD && !redirect_valid;
  assign out_pc     = req_addr;
  assign out_instr  = instr_buf;
  assign out_exc    = exc_buf;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= PC_RESET;
      req_addr  <= PC_RESET;
      state     <= S_REQ;
      instr_buf <= 32'd0;
      exc_buf   <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
            // With nothing left on the bus the new target can be requested directly.
            if (iresp_data_ok || misaligned) begin
              req_addr <= redirect_pc;
            end else begin
              state <= S_DISCARD;
            end
          end else if (misaligned) begin
            instr_buf <= 32'd0;
            exc_buf   <= 1'b1;
            state     <= S_HOLD;
          end else if (iresp_data_ok) begin
            instr_buf <= iresp_data;
            exc_buf   <= 1'b0;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc       <= redirect_pc;
            req_addr <= redirect_pc;
            state    <= S_REQ;
          end else if (out_ready) begin
            pc       <= pcplus4;
            req_addr <= pcplus4;
            state    <= S_REQ;
          end
        end
        S_DISCARD: begin
          // req_addr keeps the stale address on the bus until its response drains.
          if (iresp_data_ok) begin
            if (redirect_valid) begin
              pc       <= redirect_pc;
              req_addr <= redirect_pc;
            end else begin
              req_addr <= pc;
            end
            state <= S_REQ;
          end else if (redirect_valid) begin
            pc <= redirect_pc;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pcreg.sv
// Bench for fetch_pcreg: directed scenarios plus a randomized run against a
// fetch-slot reference model and a memory-content scoreboard.
module tb_fetch_pcreg;

  localparam logic [63:0] PCR = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] pc;
  logic [63:0] pcplus4 = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural PC, address of the current fetch slot,
  // whether a fetched slot is waiting for decode, and whether the request on
  // the bus belongs to a squashed path.
  logic [63:0] m_pc = PCR;
  logic [63:0] m_addr = PCR;
  logic        m_full = 1'b0;
  logic        m_stale = 1'b0;
  logic [31:0] m_instr = '0;
  logic        m_exc = 1'b0;

  fetch_pcreg #(.PC_RESET(PCR)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pcplus4(pcplus4),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  task automatic drive(input logic rst, input logic rd, input logic [63:0] rpc,
                       input logic dok, input logic [31:0] data, input logic rdy);
    @(negedge clk);
    reset = rst; redirect_valid = rd; redirect_pc = rpc;
    iresp_data_ok = dok; iresp_data = data; out_ready = rdy;
    pcplus4 = m_pc + 64'd4;
    #1;
  endtask

  task automatic adv();
    @(posedge clk);
    if (reset) begin
      m_pc = PCR; m_addr = PCR; m_full = 1'b0; m_stale = 1'b0; m_instr = '0; m_exc = 1'b0;
    end else if (m_full) begin
      if (redirect_valid) begin
        m_pc = redirect_pc; m_addr = redirect_pc; m_full = 1'b0;
      end else if (out_ready) begin
        m_pc = pcplus4; m_addr = pcplus4; m_full = 1'b0;
      end
    end else if (m_stale) begin
      if (iresp_data_ok) begin
        if (redirect_valid) m_pc = redirect_pc;
        m_addr = m_pc; m_stale = 1'b0;
      end else if (redirect_valid) begin
        m_pc = redirect_pc;
      end
    end else begin
      if (redirect_valid) begin
        m_pc = redirect_pc;
        if (iresp_data_ok || m_addr[1:0] != 2'b00) m_addr = redirect_pc;
        else m_stale = 1'b1;
      end else if (m_addr[1:0] != 2'b00) begin
        m_full = 1'b1; m_instr = '0; m_exc = 1'b1;
      end else if (iresp_data_ok) begin
        m_full = 1'b1; m_instr = iresp_data; m_exc = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    drive(1, 0, '0, 0, '0, 0);
    adv();
  endtask

  task automatic test_reset();
    drive(1, 1, 64'h1234, 1, 32'hFFFF_FFFF, 1);
    checks++;
    if ({ireq_valid, out_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_valids: got %b exp 00", {ireq_valid, out_valid});
    end
    adv();
    drive(1, 0, '0, 0, '0, 0);
    checks++;
    if ({ireq_valid, out_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_valids2: got %b exp 00", {ireq_valid, out_valid});
    end
    adv();
    drive(0, 0, '0, 0, '0, 0);
    checks++;
    if ({pc, ireq_addr, ireq_valid, out_valid} !== {PCR, PCR, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_state: got pc=%h addr=%h iv=%b ov=%b exp pc=addr=%h iv=1 ov=0",
                         pc, ireq_addr, ireq_valid, out_valid, PCR);
    end
    adv();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      logic [63:0] a;
      a = PCR + 64'(4 * i);
      drive(0, 0, '0, 1, 32'h0000_0013, 1);
      checks++;
      if ({ireq_valid, ireq_addr, out_valid} !== {1'b1, a, 1'b0}) begin
        errors++; $display("FAIL seq_req%0d: got iv=%b addr=%h ov=%b exp iv=1 addr=%h ov=0",
                           i, ireq_valid, ireq_addr, out_valid, a);
      end
      adv();
      drive(0, 0, '0, 0, '0, 1);
      checks++;
      if ({out_valid, out_pc, out_instr, out_exc, ireq_valid} !== {1'b1, a, 32'h13, 1'b0, 1'b0}) begin
        errors++; $display("FAIL seq_out%0d: got ov=%b pc=%h instr=%h exc=%b iv=%b exp ov=1 pc=%h instr=13",
                           i, out_valid, out_pc, out_instr, out_exc, ireq_valid, a);
      end
      adv();
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(0, 0, '0, 1, 32'h0000_0513, 0);
    adv();
    for (int i = 0; i < 5; i++) begin
      // a stray response while holding must be ignored
      drive(0, 0, '0, i == 2, 32'hBAD0_BAD0, 0);
      checks++;
      if ({out_valid, out_pc, out_instr, ireq_valid} !== {1'b1, PCR, 32'h0000_0513, 1'b0}) begin
        errors++; $display("FAIL stall%0d: got ov=%b pc=%h instr=%h iv=%b exp ov=1 pc=%h instr=00000513 iv=0",
                           i, out_valid, out_pc, out_instr, ireq_valid, PCR);
      end
      adv();
    end
    drive(0, 0, '0, 0, '0, 1);
    adv();
    drive(0, 0, '0, 0, '0, 0);
    checks++;
    if ({pc, ireq_addr, ireq_valid} !== {PCR + 64'd4, PCR + 64'd4, 1'b1}) begin
      errors++; $display("FAIL stall_release: got pc=%h addr=%h iv=%b exp %h iv=1", pc, ireq_addr, ireq_valid, PCR + 64'd4);
    end
    adv();
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    drive(0, 0, '0, 1, 32'h13, 0); adv();
    drive(0, 0, '0, 0, '0, 1); adv();
    drive(0, 1, PCR + 64'h100, 0, '0, 0);
    adv();
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, '0, 0, '0, 1);
      checks++;
      if ({ireq_valid, ireq_addr, out_valid, pc} !== {1'b1, PCR + 64'd4, 1'b0, PCR + 64'h100}) begin
        errors++; $display("FAIL discard_hold%0d: got iv=%b addr=%h ov=%b pc=%h exp iv=1 addr=%h ov=0 pc=%h",
                           k, ireq_valid, ireq_addr, out_valid, pc, PCR + 64'd4, PCR + 64'h100);
      end
      adv();
    end
    drive(0, 0, '0, 1, 32'hDEAD_BEEF, 1);
    adv();
    drive(0, 0, '0, 0, '0, 1);
    checks++;
    if ({ireq_valid, ireq_addr, out_valid} !== {1'b1, PCR + 64'h100, 1'b0}) begin
      errors++; $display("FAIL discard_drain: got iv=%b addr=%h ov=%b exp iv=1 addr=%h ov=0",
                         ireq_valid, ireq_addr, out_valid, PCR + 64'h100);
    end
    adv();
    // repeated redirects while draining: the last one wins
    drive(0, 1, PCR + 64'h300, 0, '0, 0); adv();
    drive(0, 1, PCR + 64'h400, 0, '0, 0);
    checks++;
    if ({pc, ireq_addr} !== {PCR + 64'h300, PCR + 64'h100}) begin
      errors++; $display("FAIL discard_split: got pc=%h addr=%h exp pc=%h addr=%h", pc, ireq_addr, PCR + 64'h300, PCR + 64'h100);
    end
    adv();
    drive(0, 1, PCR + 64'h500, 1, 32'h1111_1111, 0); adv();
    drive(0, 0, '0, 0, '0, 0);
    checks++;
    if ({pc, ireq_addr, ireq_valid, out_valid} !== {PCR + 64'h500, PCR + 64'h500, 1'b1, 1'b0}) begin
      errors++; $display("FAIL discard_last_wins: got pc=%h addr=%h iv=%b ov=%b exp %h iv=1 ov=0",
                         pc, ireq_addr, ireq_valid, out_valid, PCR + 64'h500);
    end
    adv();
  endtask

  task automatic test_redirect_hold();
    drive(0, 0, '0, 1, 32'h13, 0); adv();
    drive(0, 1, PCR + 64'h200, 0, '0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_redirect_mask: got ov=%b exp 0", out_valid);
    end
    adv();
    drive(0, 0, '0, 0, '0, 0);
    checks++;
    if ({ireq_valid, ireq_addr, pc} !== {1'b1, PCR + 64'h200, PCR + 64'h200}) begin
      errors++; $display("FAIL hold_redirect_next: got iv=%b addr=%h pc=%h exp iv=1 %h", ireq_valid, ireq_addr, pc, PCR + 64'h200);
    end
    adv();
  endtask

  task automatic test_misaligned();
    drive(0, 0, '0, 1, 32'h13, 0); adv();
    drive(0, 1, PCR + 64'h102, 0, '0, 0); adv();
    drive(0, 0, '0, 0, '0, 0);
    checks++;
    if ({ireq_valid, pc} !== {1'b0, PCR + 64'h102}) begin
      errors++; $display("FAIL misalign_noreq: got iv=%b pc=%h exp iv=0 pc=%h", ireq_valid, pc, PCR + 64'h102);
    end
    adv();
    drive(0, 0, '0, 0, '0, 0);
    checks++;
    if ({out_valid, out_exc, out_pc, out_instr, ireq_valid} !== {1'b1, 1'b1, PCR + 64'h102, 32'h0, 1'b0}) begin
      errors++; $display("FAIL misalign_out: got ov=%b exc=%b pc=%h instr=%h iv=%b exp ov=1 exc=1 pc=%h instr=0 iv=0",
                         out_valid, out_exc, out_pc, out_instr, ireq_valid, PCR + 64'h102);
    end
    adv();
    drive(0, 0, '0, 0, '0, 1); adv();
    drive(0, 0, '0, 0, '0, 0);
    checks++;
    if ({ireq_valid, pc} !== {1'b0, PCR + 64'h106}) begin
      errors++; $display("FAIL misalign_next: got iv=%b pc=%h exp iv=0 pc=%h", ireq_valid, pc, PCR + 64'h106);
    end
    adv();
  endtask

  task automatic test_reset_discard();
    do_reset();
    drive(0, 0, '0, 0, '0, 0); adv();
    drive(0, 1, PCR + 64'h700, 0, '0, 0); adv();
    drive(1, 0, '0, 0, '0, 0);
    checks++;
    if ({ireq_valid, out_valid} !== 2'b00) begin
      errors++; $display("FAIL rst_discard_during: got iv=%b ov=%b exp 0 0", ireq_valid, out_valid);
    end
    adv();
    drive(0, 0, '0, 0, '0, 0);
    checks++;
    if ({pc, ireq_addr, ireq_valid} !== {PCR, PCR, 1'b1}) begin
      errors++; $display("FAIL rst_discard_after: got pc=%h addr=%h iv=%b exp %h iv=1", pc, ireq_addr, ireq_valid, PCR);
    end
    adv();
  endtask

  task automatic test_random();
    int bus_cnt = -1;
    int xfers = 0;
    int mode;
    logic exp_iv, exp_ov;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      reset = ($urandom % 100) == 0;
      #1;
      if (reset) bus_cnt = -1;
      iresp_data_ok = 1'b0;
      iresp_data = $urandom;
      if (ireq_valid) begin
        if (bus_cnt < 0) bus_cnt = $urandom_range(0, 3);
        if (bus_cnt == 0) begin
          iresp_data_ok = 1'b1; iresp_data = mem_word(ireq_addr); bus_cnt = -1;
        end else begin
          bus_cnt--;
        end
      end else if (($urandom % 20) == 0) begin
        iresp_data_ok = 1'b1;
      end
      redirect_valid = ($urandom % 10) == 0;
      mode = $urandom_range(0, 99);
      if (mode < 70)      redirect_pc = PCR + 64'(4 * $urandom_range(0, 255));
      else if (mode < 85) redirect_pc = PCR + 64'(4 * $urandom_range(0, 255) + $urandom_range(1, 3));
      else                redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(0, 3));
      out_ready = ($urandom % 10) < 6;
      pcplus4 = m_pc + 64'd4;
      #1;
      exp_iv = !reset && !m_full && (m_stale || m_addr[1:0] == 2'b00);
      exp_ov = !reset && m_full && !redirect_valid;
      checks++;
      if (reset) begin
        if ({ireq_valid, out_valid} !== 2'b00) begin
          errors++; $display("FAIL rnd_reset cyc %0d: got iv=%b ov=%b exp 0 0", n, ireq_valid, out_valid);
        end
      end else if ({ireq_valid, ireq_addr, out_valid, pc} !== {exp_iv, m_addr, exp_ov, m_pc}) begin
        errors++; $display("FAIL rnd_ctrl cyc %0d: got iv=%b addr=%h ov=%b pc=%h exp iv=%b addr=%h ov=%b pc=%h",
                           n, ireq_valid, ireq_addr, out_valid, pc, exp_iv, m_addr, exp_ov, m_pc);
      end
      if (exp_ov) begin
        checks++;
        if ({out_pc, out_instr, out_exc} !== {m_addr, m_instr, m_exc}) begin
          errors++; $display("FAIL rnd_out cyc %0d: got pc=%h instr=%h exc=%b exp pc=%h instr=%h exc=%b",
                             n, out_pc, out_instr, out_exc, m_addr, m_instr, m_exc);
        end
      end
      if (out_valid && out_ready) begin
        xfers++;
        checks++;
        if (out_instr !== (out_exc ? 32'h0 : mem_word(out_pc))) begin
          errors++; $display("FAIL rnd_memword cyc %0d: pc=%h got instr=%h exp %h",
                             n, out_pc, out_instr, out_exc ? 32'h0 : mem_word(out_pc));
        end
      end
      adv();
    end
    checks++;
    if (xfers < 50) begin
      errors++; $display("FAIL rnd_progress: got %0d transfers exp at least 50", xfers);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_inflight();
    test_redirect_hold();
    test_misaligned();
    test_reset_discard();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
